stream_decrypter: RTL and testbench

Receive-side counterpart of the 4-bit-ARX keystream encrypter: accepts a serial ciphertext bit stream over a valid/ready handshake, regenerates the identical keystream from key, nonce and counter, XORs it out, and assembles recovered plaintext into BYTE_W-bit words on a registered valid/ready output port. Sits between the serial link receiver and the byte-wide consumer.

---
 rtl/stream_decrypter_if.sv | 22 ++
 rtl/stream_decrypter.sv | 123 ++++++++++++
 tb/tb_stream_decrypter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_decrypter_if.sv
// Ciphertext-in / plaintext-out handshake bundle for stream_decrypter.
// The slave modport is the decrypter side; master is the link/consumer side.
interface stream_decrypter_if #(
   parameter int BYTE_W = 8
);
   logic              in_valid;
   logic              in_bit;
   logic              in_ready;
   logic              out_valid;
   logic [BYTE_W-1:0] out_data;
   logic              out_ready;

   modport slave (
      input  in_valid, in_bit, out_ready,
      output in_ready, out_valid, out_data
   );

   modport master (
      output in_valid, in_bit, out_ready,
      input  in_ready, out_valid, out_data
   );
endinterface

// File: rtl/stream_decrypter.sv
// Serial ARX-keystream decrypter assembling recovered plaintext into BYTE_W-bit words.
// Define STREAM_DEC_LSB_FIRST_EN to place the first bit of a word in out_data[0].
module stream_decrypter #(
   parameter int         BYTE_W = 8,
   parameter logic [3:0] CONST  = 4'b1101
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start_i,
   input  logic [7:0]          key_i,
   input  logic [1:0]          nonce_i,
   input  logic [1:0]          init_ctr_i,
   stream_decrypter_if.slave   bus,
   output logic                busy_o,
   output logic [1:0]          ctr_o
);

   localparam int CW = (BYTE_W > 2) ? $clog2(BYTE_W) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state_q;
   logic [7:0]        key_q;
   logic [1:0]        nonce_q;
   logic [1:0]        ctr_q;
   logic [CW-1:0]     bitCnt_q;
   logic [BYTE_W-1:0] shift_q;
   logic [BYTE_W-1:0] outData_q;
   logic              outValid_q;

   logic              ks;
   logic              plainBit;
   logic              lastBit;
   logic              inReady;
   logic              accept;
   logic              loadWord;
   logic [BYTE_W-1:0] nextWord;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      case (x)
         4'h0: sbox = 4'h0;  4'h1: sbox = 4'hA;  4'h2: sbox = 4'hD;  4'h3: sbox = 4'h7;
         4'h4: sbox = 4'hE;  4'h5: sbox = 4'h4;  4'h6: sbox = 4'h3;  4'h7: sbox = 4'h9;
         4'h8: sbox = 4'h5;  4'h9: sbox = 4'hF;  4'hA: sbox = 4'h8;  4'hB: sbox = 4'h2;
         4'hC: sbox = 4'hB;  4'hD: sbox = 4'h1;  4'hE: sbox = 4'h6;  default: sbox = 4'hC;
      endcase
   endfunction

   // Only the second-round column selected by the counter is needed, so the
   // 2-bit index arithmetic wraps mod 4 for free.
   function automatic logic keystreamBit(input logic [7:0] k, input logic [1:0] n,
                                         input logic [1:0] c);
      logic [3:0] t;
      logic [3:0] r;
      logic [3:0] u [4];
      logic [3:0] f;
      t = {c, n};
      for (int i = 0; i < 4; i++) begin
         r    = sbox({CONST[3-i], k[7-2*i], k[6-2*i], t[3-i]});
         u[i] = {r[0], r[1], r[2], r[3]};
      end
      f = sbox({u[0][c], u[1][c + 2'd1], u[2][c + 2'd2], u[3][c + 2'd3]});
      keystreamBit = f[3];
   endfunction

   always_comb begin
      ks       = keystreamBit(key_q, nonce_q, ctr_q);
      plainBit = bus.in_bit ^ ks;
      lastBit  = (bitCnt_q == CW'(BYTE_W - 1));
      inReady  = (state_q == RUN) & ~(lastBit & outValid_q & ~bus.out_ready);
      accept   = bus.in_valid & inReady;
      loadWord = accept & lastBit & ~start_i;
`ifdef STREAM_DEC_LSB_FIRST_EN
      nextWord = {plainBit, shift_q[BYTE_W-1:1]};
`else
      nextWord = {shift_q[BYTE_W-2:0], plainBit};
`endif
   end

   // start takes priority over an accept in the same cycle and never touches
   // a word already waiting on the output port.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         key_q      <= '0;
         nonce_q    <= '0;
         ctr_q      <= '0;
         bitCnt_q   <= '0;
         shift_q    <= '0;
         outData_q  <= '0;
         outValid_q <= 1'b0;
      end else begin
         if (start_i) begin
            state_q  <= RUN;
            key_q    <= key_i;
            nonce_q  <= nonce_i;
            ctr_q    <= init_ctr_i;
            bitCnt_q <= '0;
         end else if (accept) begin
            shift_q <= nextWord;
            ctr_q   <= ctr_q + 2'd1;
            if (lastBit) begin
               bitCnt_q  <= '0;
               outData_q <= nextWord;
            end else begin
               bitCnt_q <= bitCnt_q + CW'(1);
            end
         end

         if (loadWord) begin
            outValid_q <= 1'b1;
         end else if (bus.out_ready) begin
            outValid_q <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = inReady;
   assign bus.out_valid = outValid_q;
   assign bus.out_data  = outData_q;
   assign busy_o        = (state_q == RUN);
   assign ctr_o         = ctr_q;

endmodule

// File: tb/tb_stream_decrypter.sv
// Directed bench for stream_decrypter: vector table, backpressure, restart,
// reset and a loopback against a behavioural encrypter.
module tb_stream_decrypter;

   localparam logic [63:0] SBOX_TAB = 64'hC61B_28F5_934E_7DA0;
   localparam logic [3:0]  KS_CONST = 4'b1101;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] key;
   logic [1:0] nonce;
   logic [1:0] initCtr;
   logic       busy;
   logic [1:0] ctr;

   int checks = 0;
   int errors = 0;

   stream_decrypter_if #(.BYTE_W(8)) bus ();

   stream_decrypter #(.BYTE_W(8), .CONST(KS_CONST)) dut (
      .clk        (clk),
      .reset      (reset),
      .start_i    (start),
      .key_i      (key),
      .nonce_i    (nonce),
      .init_ctr_i (initCtr),
      .bus        (bus),
      .busy_o     (busy),
      .ctr_o      (ctr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] key;
      logic [1:0] nonce;
      logic [1:0] initCtr;
      logic [7:0] cipher;
      logic [7:0] plainMsb;
   } vec_t;

   vec_t vecs [4];

   function automatic logic [7:0] rev8(input logic [7:0] x);
      logic [7:0] y;
      for (int i = 0; i < 8; i++) y[i] = x[7-i];
      return y;
   endfunction

   // Expected word given MSB-first assembly order.
   function automatic logic [7:0] orderWord(input logic [7:0] msbFirst);
`ifdef STREAM_DEC_LSB_FIRST_EN
      return rev8(msbFirst);
`else
      return msbFirst;
`endif
   endfunction

   // Reference encrypter keystream, evaluating all four round-2 columns.
   function automatic logic modelKs(input logic [7:0] k, input logic [1:0] n,
                                    input logic [1:0] c);
      logic [63:0] tab;
      logic [3:0]  cst;
      logic [3:0]  t;
      logic [3:0]  x;
      logic [3:0]  r;
      logic [3:0]  u [4];
      logic [3:0]  f [4];
      tab = SBOX_TAB;
      cst = KS_CONST;
      t   = {c, n};
      for (int i = 0; i < 4; i++) begin
         x = {cst[3-i], k[7-2*i], k[6-2*i], t[3-i]};
         r = tab[4*x +: 4];
         u[i] = {r[0], r[1], r[2], r[3]};
      end
      for (int j = 0; j < 4; j++) begin
         x = {u[0][j], u[1][(j+1)%4], u[2][(j+2)%4], u[3][(j+3)%4]};
         f[j] = tab[4*x +: 4];
      end
      return f[c][3];
   endfunction

   task automatic checkOutput(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // Called just after a falling edge; pulses start for one rising edge.
   task automatic applyStimulus(input logic [7:0] k, input logic [1:0] n,
                                input logic [1:0] c, input logic withBit);
      key = k; nonce = n; initCtr = c; start = 1'b1;
      bus.in_valid = withBit; bus.in_bit = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; bus.in_valid = 1'b0;
   endtask

   // Offers one bit starting just after a falling edge; returns after the accept edge.
   task automatic sendBit(input logic b);
      bit done;
      done = 0;
      bus.in_valid = 1'b1;
      bus.in_bit   = b;
      for (int k = 0; k < 50 && !done; k++) begin
         #1;
         if (bus.in_ready) begin
            @(posedge clk);
            done = 1;
         end
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout actual=0 expected=1");
      end
   endtask

   task automatic sendByte(input logic [7:0] bits);
      for (int i = 7; i >= 0; i--) sendBit(bits[i]);
   endtask

   initial begin
      logic [7:0] lbKey;
      logic [1:0] lbNonce;
      logic [1:0] lbCtr;
      logic [1:0] mCtr;
      logic [7:0] expWord;
      logic       p;

      vecs[0] = '{8'h00, 2'd0, 2'd0, 8'h00, 8'h55};
      vecs[1] = '{8'h00, 2'd0, 2'd1, 8'h00, 8'hAA};
      vecs[2] = '{8'h00, 2'd0, 2'd1, 8'hFF, 8'h55};
      vecs[3] = '{8'h00, 2'd0, 2'd0, 8'hFF, 8'hAA};

      reset = 1'b1; start = 1'b0; key = '0; nonce = '0; initCtr = '0;
      bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("reset_in_ready", 16'(bus.in_ready), 16'd0);
      checkOutput("reset_out_valid", 16'(bus.out_valid), 16'd0);
      checkOutput("reset_out_data", 16'(bus.out_data), 16'd0);
      checkOutput("reset_busy", 16'(busy), 16'd0);
      checkOutput("reset_ctr", 16'(ctr), 16'd0);
      @(negedge clk);

      // Table-driven single words with free-running consumer.
      for (int v = 0; v < 4; v++) begin
         applyStimulus(vecs[v].key, vecs[v].nonce, vecs[v].initCtr, 1'b0);
         checkOutput($sformatf("vec%0d_busy", v), 16'(busy), 16'd1);
         checkOutput($sformatf("vec%0d_ctr_start", v), 16'(ctr), 16'(vecs[v].initCtr));
         sendByte(vecs[v].cipher);
         checkOutput($sformatf("vec%0d_valid", v), 16'(bus.out_valid), 16'd1);
         checkOutput($sformatf("vec%0d_data", v), 16'(bus.out_data),
                     16'(orderWord(vecs[v].plainMsb)));
         checkOutput($sformatf("vec%0d_ctr_end", v), 16'(ctr), 16'(vecs[v].initCtr));
         @(negedge clk);
         checkOutput($sformatf("vec%0d_valid_clr", v), 16'(bus.out_valid), 16'd0);
      end

      // Backpressure: second word stalls on its last bit until the consumer drains.
      bus.out_ready = 1'b0;
      applyStimulus(8'h00, 2'd0, 2'd0, 1'b0);
      sendByte(8'h00);
      for (int i = 0; i < 7; i++) sendBit(1'b1);
      checkOutput("bp_hold_valid", 16'(bus.out_valid), 16'd1);
      checkOutput("bp_hold_data", 16'(bus.out_data), 16'(orderWord(8'h55)));
      bus.in_valid = 1'b1; bus.in_bit = 1'b1;
      #1;
      checkOutput("bp_stall_ready", 16'(bus.in_ready), 16'd0);
      @(negedge clk);
      #1;
      checkOutput("bp_stall_ready2", 16'(bus.in_ready), 16'd0);
      checkOutput("bp_stall_data", 16'(bus.out_data), 16'(orderWord(8'h55)));
      bus.out_ready = 1'b1;
      #1;
      checkOutput("bp_release_ready", 16'(bus.in_ready), 16'd1);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      checkOutput("bp_word2_valid", 16'(bus.out_valid), 16'd1);
      checkOutput("bp_word2_data", 16'(bus.out_data), 16'(orderWord(8'hAA)));
      @(negedge clk);
      checkOutput("bp_word2_clr", 16'(bus.out_valid), 16'd0);

      // Restart after 3 bits, with a bit offered in the start cycle.
      applyStimulus(8'h00, 2'd0, 2'd2, 1'b0);
      for (int i = 0; i < 3; i++) sendBit(1'b1);
      applyStimulus(8'h00, 2'd0, 2'd1, 1'b1);
      checkOutput("restart_ctr", 16'(ctr), 16'd1);
      sendByte(8'h00);
      checkOutput("restart_valid", 16'(bus.out_valid), 16'd1);
      checkOutput("restart_data", 16'(bus.out_data), 16'(orderWord(8'hAA)));
      @(negedge clk);

      // start while a word is pending, then reset mid-word.
      bus.out_ready = 1'b0;
      applyStimulus(8'h00, 2'd0, 2'd0, 1'b0);
      sendByte(8'hFF);
      applyStimulus(8'h00, 2'd0, 2'd1, 1'b0);
      checkOutput("pend_start_valid", 16'(bus.out_valid), 16'd1);
      checkOutput("pend_start_data", 16'(bus.out_data), 16'(orderWord(8'hAA)));
      checkOutput("pend_start_ctr", 16'(ctr), 16'd1);
      for (int i = 0; i < 3; i++) sendBit(1'b0);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("rst_out_valid", 16'(bus.out_valid), 16'd0);
      checkOutput("rst_out_data", 16'(bus.out_data), 16'd0);
      checkOutput("rst_busy", 16'(busy), 16'd0);
      checkOutput("rst_ctr", 16'(ctr), 16'd0);
      checkOutput("rst_in_ready", 16'(bus.in_ready), 16'd0);
      @(negedge clk);
      reset = 1'b0;
      bus.out_ready = 1'b1; bus.in_valid = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("idle_in_ready", 16'(bus.in_ready), 16'd0);
      bus.in_valid = 1'b0;
      @(negedge clk);

      // Loopback against the reference encrypter.
      lbKey   = 8'($urandom);
      lbNonce = 2'($urandom);
      lbCtr   = 2'($urandom);
      applyStimulus(lbKey, lbNonce, lbCtr, 1'b0);
      mCtr = lbCtr;
      for (int w = 0; w < 8; w++) begin
         expWord = '0;
         for (int b = 0; b < 8; b++) begin
            p = 1'($urandom);
`ifdef STREAM_DEC_LSB_FIRST_EN
            expWord = {p, expWord[7:1]};
`else
            expWord = {expWord[6:0], p};
`endif
            sendBit(p ^ modelKs(lbKey, lbNonce, mCtr));
            mCtr = mCtr + 2'd1;
         end
         checkOutput($sformatf("loop%0d_valid", w), 16'(bus.out_valid), 16'd1);
         checkOutput($sformatf("loop%0d_data", w), 16'(bus.out_data), 16'(expWord));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
